// File: rtl/uart_mem_pkg.sv
// Shared constants, state encoding and command opcodes for the UART <-> line-memory DMA.
package uart_mem_pkg;
  localparam int ADDR_W = 6;
  localparam int DATA_W = 1024;
  localparam int BE_W   = DATA_W / 8;
  localparam int LEN_W  = 13;
  localparam int LANES  = 128;
  localparam int LANE_W = $clog2(LANES);

  typedef enum logic [2:0] {
    S_IDLE, S_FILL, S_WR, S_RD_REQ, S_RD_WAIT, S_DRAIN, S_DONE
  } state_e;

  localparam logic OP_FILL  = 1'b0;
  localparam logic OP_DRAIN = 1'b1;
endpackage

// File: rtl/uart_mem_line_buf.sv
// One memory line of staging: packs FILL bytes with a byte-enable mask, or holds a
// read-back line that is walked lane by lane during DRAIN.
module uart_mem_line_buf
  import uart_mem_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clr_i,
  input  logic              wr_en_i,
  input  logic [7:0]        wr_byte_i,
  input  logic              load_en_i,
  input  logic [DATA_W-1:0] load_data_i,
  input  logic              adv_i,
  output logic [LANE_W-1:0] lane_o,
  output logic [BE_W-1:0]   mask_o,
  output logic [DATA_W-1:0] line_o,
  output logic [7:0]        rd_byte_o
);
  logic [LANE_W-1:0] lane_q;
  logic [BE_W-1:0]   mask_q;
  logic [DATA_W-1:0] line_q;

  // Clearing only resets lane/mask; stale data in unmasked lanes is never written out.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lane_q <= '0;
      mask_q <= '0;
      line_q <= '0;
    end else if (clr_i) begin
      lane_q <= '0;
      mask_q <= '0;
    end else if (load_en_i) begin
      line_q <= load_data_i;
      lane_q <= '0;
    end else if (wr_en_i) begin
      line_q[{lane_q, 3'b000} +: 8] <= wr_byte_i;
      mask_q[lane_q]                <= 1'b1;
      lane_q                        <= lane_q + 1'b1;
    end else if (adv_i) begin
      lane_q <= lane_q + 1'b1;
    end
  end

  assign lane_o    = lane_q;
  assign mask_o    = mask_q;
  assign line_o    = line_q;
  assign rd_byte_o = line_q[{lane_q, 3'b000} +: 8];
endmodule

// File: rtl/uart_mem_line_dma.sv
// Avalon-MM master moving UART byte streams into (FILL) and out of (DRAIN) the
// 64 x 1024-bit line memory, one full line per access.
module uart_mem_line_dma
  import uart_mem_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [7:0]        s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [7:0]        m_data,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_chipselect,
  output logic              avm_write,
  output logic [BE_W-1:0]   avm_byteenable,
  output logic [DATA_W-1:0] avm_writedata,
  input  logic [DATA_W-1:0] avm_readdata,
  output logic              busy,
  output logic              done
);
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] line_ptr_q;
  logic [LEN_W-1:0]  rem_q;
  logic              last_q;
  logic              cmd_ready_q, busy_q, cs_q, we_q, s_ready_q, m_valid_q, done_q;

  logic              buf_clr, buf_wr, buf_load, buf_adv;
  logic [LANE_W-1:0] lane;
  logic [BE_W-1:0]   mask;
  logic [DATA_W-1:0] line;
  logic [7:0]        rd_byte;
  logic              accept, s_hs, m_hs, lane_end;

  assign accept   = cmd_valid && cmd_ready_q;
  assign s_hs     = s_valid && s_ready_q;
  assign m_hs     = m_valid_q && m_ready;
  assign lane_end = (lane == LANE_W'(LANES - 1));

  uart_mem_line_buf u_buf (
    .clk        (clk),
    .reset_n    (reset_n),
    .clr_i      (buf_clr),
    .wr_en_i    (buf_wr),
    .wr_byte_i  (s_data),
    .load_en_i  (buf_load),
    .load_data_i(avm_readdata),
    .adv_i      (buf_adv),
    .lane_o     (lane),
    .mask_o     (mask),
    .line_o     (line),
    .rd_byte_o  (rd_byte)
  );

  always_comb begin
    state_d  = state_q;
    buf_clr  = 1'b0;
    buf_wr   = 1'b0;
    buf_load = 1'b0;
    buf_adv  = 1'b0;
    case (state_q)
      S_IDLE: if (accept) begin
        buf_clr = 1'b1;
        state_d = (cmd_op == OP_FILL) ? S_FILL : S_RD_REQ;
      end
      S_FILL: if (s_hs) begin
        buf_wr = 1'b1;
        if (lane_end || rem_q == '0) state_d = S_WR;
      end
      S_WR: begin
        buf_clr = 1'b1;
        state_d = last_q ? S_DONE : S_FILL;
      end
      S_RD_REQ:  state_d = S_RD_WAIT;
      S_RD_WAIT: begin
        buf_load = 1'b1;
        state_d  = S_DRAIN;
      end
      S_DRAIN: if (m_hs) begin
        buf_adv = 1'b1;
        if (rem_q == '0)   state_d = S_DONE;
        else if (lane_end) state_d = S_RD_REQ;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output flags are decoded from the next state so they are registered and all low in reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      line_ptr_q  <= '0;
      rem_q       <= '0;
      last_q      <= 1'b0;
      cmd_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      cs_q        <= 1'b0;
      we_q        <= 1'b0;
      s_ready_q   <= 1'b0;
      m_valid_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= (state_d == S_IDLE);
      busy_q      <= (state_d != S_IDLE);
      cs_q        <= (state_d == S_WR) || (state_d == S_RD_REQ);
      we_q        <= (state_d == S_WR);
      s_ready_q   <= (state_d == S_FILL);
      m_valid_q   <= (state_d == S_DRAIN);
      done_q      <= (state_d == S_DONE);
      if (state_q == S_IDLE && accept) begin
        line_ptr_q <= cmd_addr;
        rem_q      <= cmd_len;
        last_q     <= 1'b0;
      end
      if (buf_wr) begin
        rem_q  <= rem_q - 1'b1;
        last_q <= (rem_q == '0);
      end
      if (state_q == S_WR) line_ptr_q <= line_ptr_q + 1'b1;
      if (buf_adv) begin
        rem_q <= rem_q - 1'b1;
        if (lane_end) line_ptr_q <= line_ptr_q + 1'b1;
      end
    end
  end

  assign cmd_ready      = cmd_ready_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign s_ready        = s_ready_q;
  assign m_valid        = m_valid_q;
  assign m_data         = m_valid_q ? rd_byte : 8'h00;
  assign avm_chipselect = cs_q;
  assign avm_write      = we_q;
  assign avm_address    = cs_q ? line_ptr_q : '0;
  assign avm_byteenable = we_q ? mask : (cs_q ? '1 : '0);
  assign avm_writedata  = we_q ? line : '0;
endmodule

// File: tb/tb_uart_mem_line_dma.sv
// Randomized bench: a line-memory slave, a byte-level reference model of the
// memory image and of the expected Avalon/stream traffic, and a per-cycle checker.
module tb_uart_mem_line_dma;
  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          cmd_valid = 1'b0, cmd_op = 1'b0;
  logic [5:0]    cmd_addr = '0;
  logic [12:0]   cmd_len = '0;
  logic          s_valid = 1'b0;
  logic [7:0]    s_data = '0;
  logic          m_ready = 1'b1;
  logic          cmd_ready, s_ready, m_valid, avm_chipselect, avm_write, busy, done;
  logic [7:0]    m_data;
  logic [5:0]    avm_address;
  logic [127:0]  avm_byteenable;
  logic [1023:0] avm_writedata, avm_readdata;

  uart_mem_line_dma dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .avm_address(avm_address), .avm_chipselect(avm_chipselect), .avm_write(avm_write),
    .avm_byteenable(avm_byteenable), .avm_writedata(avm_writedata),
    .avm_readdata(avm_readdata), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct { logic [5:0] addr; logic [127:0] be; logic [1023:0] data; } wr_t;
  wr_t         wr_q[$];
  logic [5:0]  rd_q[$];
  logic [7:0]  by_q[$];

  logic [1023:0] env_mem [64];
  logic [1023:0] pre_mem [64];
  logic [1023:0] ref_mem [64];
  logic [7:0]    fbytes [8192];
  logic          preload = 1'b1;
  logic          rdy_mode = 1'b0;
  int            n_chk = 0, n_fail = 0;
  int            cyc = 0, wr_cnt = 0, rd_cnt = 0;
  logic [127:0]  last_be = '0;

  task automatic chk(input bit ok, input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [1023:0] expand(input logic [127:0] be);
    logic [1023:0] r;
    for (int k = 0; k < 128; k++) r[8*k +: 8] = {8{be[k]}};
    return r;
  endfunction

  // Line memory slave: byte-enabled writes, registered reads (latency 1).
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (preload) begin
      for (int l = 0; l < 64; l++) env_mem[l] <= pre_mem[l];
    end else if (avm_chipselect) begin
      if (avm_write) begin
        for (int k = 0; k < 128; k++)
          if (avm_byteenable[k]) env_mem[avm_address][8*k +: 8] <= avm_writedata[8*k +: 8];
      end else begin
        avm_readdata <= env_mem[avm_address];
      end
    end
  end

  initial forever begin
    @(posedge clk); #1;
    m_ready = rdy_mode ? 1'($urandom % 2) : 1'b1;
  end

  // Per-cycle checker against the expected traffic queues.
  bit         prev_ev = 1'b0, stall_prev = 1'b0;
  logic [7:0] stall_data = '0;
  always @(negedge clk) begin
    bit   ev;
    wr_t  w;
    logic [5:0] ra;
    logic [7:0] eb;
    ev = 1'b0;
    if (avm_chipselect && avm_write) begin
      wr_cnt++; ev = 1'b1; last_be = avm_byteenable;
      if (wr_q.size() == 0) chk(1'b0, "unexpected_write", 128'(avm_address), 128'h0);
      else begin
        w = wr_q.pop_front();
        chk(avm_address == w.addr, "wr_addr", 128'(avm_address), 128'(w.addr));
        chk(avm_byteenable == w.be, "wr_be", avm_byteenable, w.be);
        chk((avm_writedata & expand(w.be)) == w.data, "wr_data",
            avm_writedata[127:0], w.data[127:0]);
      end
    end else if (avm_chipselect) begin
      rd_cnt++;
      chk(avm_byteenable == {128{1'b1}}, "rd_be", avm_byteenable, {128{1'b1}});
      if (rd_q.size() == 0) chk(1'b0, "unexpected_read", 128'(avm_address), 128'h0);
      else begin
        ra = rd_q.pop_front();
        chk(avm_address == ra, "rd_addr", 128'(avm_address), 128'(ra));
      end
    end else begin
      chk(!avm_write && avm_address == '0 && avm_byteenable == '0 && avm_writedata == '0,
          "avm_idle_zero", {avm_write, avm_address, avm_byteenable[31:0]}, 128'h0);
    end
    if (stall_prev)
      chk(m_valid && m_data == stall_data, "m_stable", 128'({m_valid, m_data}), 128'({1'b1, stall_data}));
    if (m_valid && m_ready) begin
      ev = 1'b1;
      if (by_q.size() == 0) chk(1'b0, "unexpected_byte", 128'(m_data), 128'h0);
      else begin
        eb = by_q.pop_front();
        chk(m_data == eb, "m_data", 128'(m_data), 128'(eb));
      end
    end
    if (done) chk(prev_ev, "done_timing", 128'(prev_ev), 128'h1);
    prev_ev    = ev;
    stall_prev = m_valid && !m_ready;
    stall_data = m_data;
  end

  // Reference model: derive memory image and expected traffic from the command rules.
  task automatic model_fill(input int addr, input int len);
    wr_t w;
    int  line, lane;
    w.be = '0; w.data = '0; w.addr = '0;
    for (int i = 0; i <= len; i++) begin
      line = (addr + i / 128) % 64;
      lane = i % 128;
      ref_mem[line][8*lane +: 8] = fbytes[i];
      w.addr = line[5:0];
      w.be[lane] = 1'b1;
      w.data[8*lane +: 8] = fbytes[i];
      if (lane == 127 || i == len) begin
        wr_q.push_back(w);
        w.be = '0; w.data = '0;
      end
    end
  endtask

  task automatic model_drain(input int addr, input int len);
    int line, lane;
    for (int i = 0; i <= len; i++) begin
      line = (addr + i / 128) % 64;
      lane = i % 128;
      if (lane == 0) rd_q.push_back(line[5:0]);
      by_q.push_back(ref_mem[line][8*lane +: 8]);
    end
  endtask

  task automatic send_cmd(input logic op, input int addr, input int len);
    int n;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = 6'(addr); cmd_len = 13'(len);
    n = 0;
    while (!cmd_ready && n < 1000) begin @(posedge clk); #1; n++; end
    if (n >= 1000) chk(1'b0, "cmd_accept_timeout", 128'(n), 128'h0);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic feed(input int nb);
    int i, g;
    i = 0; g = 0;
    while (i < nb && g < 20000) begin
      s_valid = ($urandom % 4) != 0;
      s_data  = fbytes[i];
      if (s_valid && s_ready) i++;
      @(posedge clk); #1;
      g++;
    end
    s_valid = 1'b0;
    if (i < nb) chk(1'b0, "feed_timeout", 128'(i), 128'(nb));
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (!done && n < 20000);
    chk(done, "done_seen", 128'(done), 128'h1);
    @(posedge clk); #1;
  endtask

  task automatic fill_cmd(input int addr, input int len);
    model_fill(addr, len);
    send_cmd(1'b0, addr, len);
    feed(len + 1);
    wait_done();
    chk(wr_q.size() == 0, "fill_writes_all", 128'(wr_q.size()), 128'h0);
  endtask

  task automatic drain_cmd(input int addr, input int len);
    int n;
    model_drain(addr, len);
    send_cmd(1'b1, addr, len);
    n = 0;
    do begin @(negedge clk); n++; end while (!m_valid && n < 20);
    chk(n == 3, "drain_first_valid_cycle", 128'(n), 128'h3);
    wait_done();
    chk(by_q.size() == 0 && rd_q.size() == 0, "drain_all_bytes", 128'(by_q.size()), 128'h0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, r0, dcyc, acyc, n, op, a, l;
    bit early;
    logic [7:0] pre;
    for (int i = 0; i < 64; i++) begin
      for (int k = 0; k < 32; k++) pre_mem[i][32*k +: 32] = $urandom;
      ref_mem[i] = pre_mem[i];
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk(!cmd_ready && !busy && !done && !s_ready && !m_valid && !avm_chipselect && m_data == 0,
        "reset_outputs", 128'({cmd_ready, busy, done, s_ready, m_valid, avm_chipselect}), 128'h0);
    @(posedge clk); #1;
    preload = 1'b0; reset_n = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk(cmd_ready && !busy, "idle_after_reset", 128'({cmd_ready, busy}), 128'h2);

    // FILL line 5 with 0..127
    for (int i = 0; i < 128; i++) fbytes[i] = 8'(i);
    w0 = wr_cnt;
    fill_cmd(5, 127);
    chk(wr_cnt - w0 == 1, "fill5_one_write", 128'(wr_cnt - w0), 128'h1);
    chk(last_be == {128{1'b1}}, "fill5_be", last_be, {128{1'b1}});
    chk(env_mem[5][135:128] == 8'h10, "fill5_byte16", 128'(env_mem[5][135:128]), 128'h10);
    chk(env_mem[5][1023:1016] == 8'h7F, "fill5_byte127", 128'(env_mem[5][1023:1016]), 128'h7F);

    // Partial line over preloaded data
    for (int i = 0; i < 10; i++) fbytes[i] = 8'(8'hA0 + i);
    pre = env_mem[2][87:80];
    fill_cmd(2, 9);
    chk(last_be == 128'h3FF, "fill2_be", last_be, 128'h3FF);
    chk(env_mem[2][79:72] == 8'hA9, "fill2_byte9", 128'(env_mem[2][79:72]), 128'hA9);
    chk(env_mem[2][87:80] == pre, "fill2_lane10_kept", 128'(env_mem[2][87:80]), 128'(pre));

    // Wrap 63 -> 0
    for (int i = 0; i < 256; i++) fbytes[i] = 8'($urandom);
    w0 = wr_cnt;
    fill_cmd(63, 255);
    chk(wr_cnt - w0 == 2, "fill63_two_writes", 128'(wr_cnt - w0), 128'h2);

    // DRAIN with backpressure
    rdy_mode = 1'b1;
    r0 = rd_cnt;
    drain_cmd(7, 199);
    chk(rd_cnt - r0 == 2, "drain7_two_reads", 128'(rd_cnt - r0), 128'h2);
    rdy_mode = 1'b0;

    // Reset mid-FILL after 50 bytes
    for (int i = 0; i < 100; i++) fbytes[i] = 8'($urandom);
    w0 = wr_cnt;
    send_cmd(1'b0, 10, 99);
    feed(50);
    reset_n = 1'b0;
    @(negedge clk);
    chk(!cmd_ready && !busy && !s_ready && !avm_chipselect && !done, "abort_outputs_zero",
        128'({cmd_ready, busy, s_ready, avm_chipselect, done}), 128'h0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk(cmd_ready, "abort_ready_after_release", 128'(cmd_ready), 128'h1);
    chk(wr_cnt == w0, "abort_no_write", 128'(wr_cnt - w0), 128'h0);

    // Held cmd_valid across a DRAIN
    model_drain(0, 3);
    model_drain(1, 0);
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_op = 1'b1; cmd_addr = 6'd0; cmd_len = 13'd3;
    n = 0;
    while (!cmd_ready && n < 100) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    cmd_addr = 6'd1; cmd_len = 13'd0;
    dcyc = -1; acyc = -1; early = 1'b0; n = 0;
    while (acyc < 0 && n < 200) begin
      @(negedge clk); n++;
      if (done) dcyc = cyc;
      if (cmd_ready) begin
        if (dcyc < 0) early = 1'b1;
        acyc = cyc;
      end
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk(!early && dcyc >= 0, "held_not_early", 128'(early), 128'h0);
    chk(acyc == dcyc + 1, "held_accept_after_done", 128'(acyc - dcyc), 128'h1);
    wait_done();
    chk(by_q.size() == 0 && rd_q.size() == 0, "held_both_drained", 128'(by_q.size()), 128'h0);

    // Random commands
    for (int r = 0; r < 8; r++) begin
      op = $urandom % 2; a = $urandom % 64; l = $urandom % 300;
      if (op == 0) begin
        for (int i = 0; i <= l; i++) fbytes[i] = 8'($urandom);
        fill_cmd(a, l);
      end else begin
        rdy_mode = 1'($urandom % 2);
        drain_cmd(a, l);
        rdy_mode = 1'b0;
      end
    end

    repeat (3) @(posedge clk);
    for (int i = 0; i < 64; i++)
      chk(env_mem[i] == ref_mem[i], "mem_image", 128'(i), (env_mem[i] ^ ref_mem[i]) >> 896);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_mem_line_dma.md
# uart_mem_line_dma

Avalon-MM master that moves byte streams into and out of the 64 x 1024-bit on-chip image line memory. It sits between the UART byte path and the memory's s1 slave. FILL commands pack incoming UART bytes into 128-byte lines and write them with per-byte enables. DRAIN commands read lines back and serialise them as a byte stream toward the UART transmitter.

## Interface
- ADDR_W, 6, line address width (64 lines)
- DATA_W, 1024, memory word width
- BE_W, 128, byte-enable width (DATA_W/8)
- LEN_W, 13, byte-count field width (max 8192 bytes = whole memory)
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE
- cmd_op  in  1  0 = FILL (stream to memory), 1 = DRAIN (memory to stream)
- cmd_addr  in  ADDR_W  starting line; transfers always begin at byte lane 0
- cmd_len  in  LEN_W  byte count minus one
- s_valid / s_ready / s_data  in/out/in  1/1/8  FILL byte input
- m_valid / m_ready / m_data  out/in/out  1/1/8  DRAIN byte output
- avm_address  out  ADDR_W  line address
- avm_chipselect, avm_write  out  1  access strobe; write qualifier
- avm_byteenable  out  BE_W  lane k enables writedata[8k+7:8k]
- avm_writedata  out  DATA_W  packed line
- avm_readdata  in  DATA_W  memory output, fixed read latency 1
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse when a command completes

## Operation
- States: IDLE, FILL, WR, RD_REQ, RD_WAIT, DRAIN, DONE.
- IDLE: accept on cmd_valid & cmd_ready. Latch the address in line_ptr and the length in remaining. Clear lane and the enable mask. FILL goes to FILL; DRAIN goes to RD_REQ.
- FILL: s_ready = 1. Each accepted byte goes to buffer lane `lane` and sets mask[lane]. Then lane++ and remaining--. Go to WR when lane reaches 127 or remaining reaches 0 (last byte).
- WR: single cycle with chipselect = 1, write = 1, byteenable = mask, writedata = buffer, and s_ready = 0. Then line_ptr++ (63 wraps to 0) and clear mask and lane. Go to DONE if the last byte was written, else back to FILL.
- Lanes not in mask are never written. A partial final line preserves the existing memory bytes.
- RD_REQ: single cycle with chipselect = 1, write = 0, byteenable = all ones. Go to RD_WAIT.
- RD_WAIT: capture avm_readdata into the buffer at the end of the cycle. Set lane = 0. Go to DRAIN.
- DRAIN: m_valid = 1 and m_data = buffer lane `lane`. On each handshake, lane++ and remaining--. After the last byte, go to DONE. Otherwise, after lane 127, line_ptr++ (with wrap) and go to RD_REQ.
- DONE: done = 1 for one cycle. Go to IDLE.
- Memory access rules:
  - avm_chipselect is high only in WR and RD_REQ.
  - avm_write is high only in WR.
  - All avm_* outputs are 0 in every other state.
- Commands are not queued. cmd_valid arriving while busy is held off by cmd_ready = 0.
- Address wrap: a transfer crossing line 63 continues at line 0. There is no error.

## Timing
- Reset values: cmd_ready = 0 during reset and 1 after release (IDLE). All other outputs are 0. The buffer is cleared.
- Asynchronous reset mid-command aborts immediately. A partially packed line is discarded, with no write.
- FILL: the line write occurs in the cycle after the 128th or last byte is accepted. Steady-state throughput is 128 bytes per 129 cycles.
- DRAIN latency: command accepted at edge E0, RD_REQ in cycle 1, readdata captured at E2, first m_valid in cycle 3. Each line costs 2 cycles of overhead.
- m_data and m_valid stay stable while m_ready = 0. s_ready does not depend combinationally on s_valid.
- done is asserted exactly one cycle after the final WR, or after the final DRAIN handshake.

## Structure
- Package uart_mem_pkg holds:
  - the constants ADDR_W, DATA_W, BE_W, LEN_W, LANES = 128;
  - the state enum;
  - the OP_FILL / OP_DRAIN encodings.
- Sub-module uart_mem_line_buf holds the 1024-bit buffer, lane counter and mask. It has three operations:
  - byte write at lane;
  - full-line load;
  - byte read at lane.
- The FSM, the address pointer and the remaining counter live in the top module.

## Test plan
- FILL addr 5, len 127 (128 bytes 0x00..0x7F): exactly one write to line 5, byteenable all ones, byte k = k. done is high one cycle later.
- FILL addr 2, len 9 (10 bytes 0xA0..0xA9) over a preloaded line: byteenable = 0x3FF. Lanes 10..127 of line 2 are unchanged on readback.
- FILL addr 63, len 255: writes go to line 63, then line 0 (wrap). Exactly two WR cycles.
- DRAIN addr 7, len 199 with random m_ready backpressure: 200 bytes out in order, with reads of line 7 then line 8. First m_valid is 3 cycles after command accept.
- Assert reset_n low mid-FILL after 50 bytes: no memory write occurs. All outputs are 0. cmd_ready = 1 after release.
- cmd_valid held during a DRAIN: the second command is accepted only after done, in the IDLE cycle.
